// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   fetch_state_e    : fetch FSM state encoding (2-bit)
//   NOP_INSTR        : instruction presented before the first fetch (addi x0, x0, 0)
//   DEFAULT_RESET_PC : default PC loaded on reset
//   align_word()     : clears the two LSBs of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's core-side and memory-side signals.
//   Core side   : pc_src, pc_target, instr_ready (to fetch);
//                 instr, instr_valid, pc, pc_plus4 (from fetch)
//   Memory side : imem_rvalid, imem_rdata (to fetch); imem_req, imem_addr (from fetch)
// modport master : the fetch unit itself
// modport slave  : everything around it (core + instruction memory)
interface instr_fetch_unit_if;

    logic        pc_src;
    logic [31:0] pc_target;
    logic        instr_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        input  pc_src,
        input  pc_target,
        input  instr_ready,
        input  imem_rvalid,
        input  imem_rdata,
        output imem_req,
        output imem_addr,
        output instr,
        output instr_valid,
        output pc,
        output pc_plus4
    );

    modport slave (
        output pc_src,
        output pc_target,
        output instr_ready,
        output imem_rvalid,
        output imem_rdata,
        input  imem_req,
        input  imem_addr,
        input  instr,
        input  instr_valid,
        input  pc,
        input  pc_plus4
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the fetch unit's memory timeout.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   i_clear  : synchronous clear to zero (has priority)
//   i_enable : count one cycle
//   o_expire : count has reached MAX_COUNT-1
// The count returns to zero on the cycle it expires so it never wraps through
// a stale value if the enable is left high.
module fetch_timeout_ctr #(
    parameter int unsigned MAX_COUNT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned   CW   = (MAX_COUNT > 2) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    assign o_expire = (r_count == LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_clear || (i_enable && o_expire)) begin
            w_count_next = '0;
        end else if (i_enable) begin
            w_count_next = r_count + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one instruction per handshake
// from a variable-latency instruction memory and presents it to the core.
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   bus            : instr_fetch_unit_if.master
//                    in : pc_src, pc_target, instr_ready, imem_rvalid, imem_rdata
//                    out: imem_req, imem_addr, instr, instr_valid, pc, pc_plus4
//   o_misalign_err : sticky, a taken redirect had pc_target[1:0] != 0
//   o_fetch_err    : sticky, at least one memory timeout occurred
// Sequence per instruction: REQ (one-cycle req pulse) -> WAIT (until rvalid or
// timeout) -> HOLD (until instr_ready) -> REQ. Errors never stall fetching.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus,
    output logic                o_misalign_err,
    output logic                o_fetch_err
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_misalign_err;
    logic        r_fetch_err;

    logic        w_capture;
    logic        w_timeout;
    logic        w_handshake;
    logic        w_misaligned;
    logic        w_expire;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    // Timeout counter runs only while waiting; leaving WAIT (or never
    // entering it) keeps it at zero so each request gets a full window.
    fetch_timeout_ctr #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != StWait),
        .i_enable (r_state == StWait),
        .o_expire (w_expire)
    );

    // Next-PC mux and adder. The adder wraps modulo 2^32 by construction.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_next  = bus.pc_src ? align_word(bus.pc_target) : w_pc_plus4;

    // pc_src/pc_target only matter on the accepting edge.
    assign w_misaligned = w_handshake && bus.pc_src && (bus.pc_target[1:0] != 2'b00);

    // FSM next-state and per-cycle strobes.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_handshake  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_state_next = StReq;
            end
            StReq: begin
                w_state_next = StWait;
            end
            StWait: begin
                // rvalid wins over an expiring count on the same cycle.
                if (bus.imem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = StHold;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = StReq;
                end
            end
            StHold: begin
                if (bus.instr_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = StReq;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers. Capture and handshake are mutually exclusive since
    // they come from different states. A timeout retries the same PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_instr        <= NOP_INSTR;
            r_instr_valid  <= 1'b0;
            r_misalign_err <= 1'b0;
            r_fetch_err    <= 1'b0;
        end else begin
            if (w_capture) begin
                r_instr       <= bus.imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_pc          <= w_pc_next;
                r_instr_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_fetch_err <= 1'b1;
            end
            if (w_misaligned) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    assign bus.imem_req    = (r_state == StReq);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;

    assign o_misalign_err  = r_misalign_err;
    assign o_fetch_err     = r_fetch_err;

endmodule
